key_event_queue: RTL and testbench
==================================

# key_event_queue

Bus-attached keyboard event queue between the PS/2 decoder and the CPU bus and interrupt path. It captures each key-press event (scan code plus ASCII) into a small FIFO so that bursts typed faster than the slow CPU clock are not lost. It exposes a DATA register (read pops) and a STATUS/CTRL register at the keyboard base address. It raises an interrupt vector with an ack handshake while events are pending.

## Interface

- `DEPTH`, default 16: FIFO entries; power of two, 2..256.
- `BASE_ADDR`, default `` `Key_base ``: byte address of DATA; STATUS/CTRL sits at `BASE_ADDR+8`.
- `IRQ_ID`, default 4'd1: value driven on `interrupt_vector` when requesting.

- `clk`, input, 1: system clock (CLOCK_50 domain); all logic on its rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `key_pressed`, input, 1: level from the PS/2 decoder, high while a make code is presented.
- `ascii_code`, input, 8: decoder ASCII; 0 means non-printable.
- `scan_code`, input, 8: decoder scan code.
- `bus_address`, input, 64: CPU bus byte address.
- `bus_read_enable`, input, 1: CPU read strobe; a level held for many `clk` cycles.
- `bus_write_enable`, input, 1: CPU write strobe; a level.
- `bus_write_data`, input, 64: write data.
- `bus_read_data`, output, 64: registered read data.
- `read_valid`, output, 1: one-cycle pulse when `bus_read_data` is updated.
- `interrupt_vector`, output, 4: `IRQ_ID` while requesting, else 0.
- `interrupt_ack`, input, 1: CPU acknowledge, level.
- `overflow`, output, 1: sticky drop flag, intended for an LED.

## Operation

- `sel_data` = (`bus_address == BASE_ADDR`). `sel_ctrl` = (`bus_address == BASE_ADDR+8`).
- Edge detection: `key_pressed`, `rd = bus_read_enable & (sel_data|sel_ctrl)` and `wr = bus_write_enable & sel_ctrl` each have a delay flop. Only rising edges act, so exactly one action occurs per CPU access regardless of strobe length.
- Push: on a `key_pressed` rising edge with `ascii_code != 0`, write entry `{scan_code, ascii_code}` (16 bits).
- FIFO pointers are log2(DEPTH)+1 bits with an explicit count 0..DEPTH. Pointers wrap modulo DEPTH. Empty means count==0; full means count==DEPTH.
- DATA read edge: load `bus_read_data` with {47'b0, valid, scan[7:0], ascii[7:0]}, where valid=!empty and the entry is the head. Pop if non-empty. If empty, load valid=0 with the byte fields at 0, and leave pointers untouched.
- STATUS read edge: load `bus_read_data` with {48'b0, count[8:0] at [15:7], 3'b0 at [6:4], irq_en [3], overflow [2], full [1], empty [0]}. No side effect.
- `bus_read_data` holds its value between reads.
- CTRL write edge:
  - bit0 = 1 flushes the FIFO (pointers and count go to 0).
  - bit1 = 1 clears `overflow`.
  - bit2 is loaded into `irq_en`.
  - Writes to DATA are ignored.
- Push while full: the entry is dropped and `overflow` is set.
- Simultaneous push and pop: both happen and count is unchanged. This also applies when full: the pop frees a slot and the push is accepted, so `overflow` is not set.
- Flush coincident with a push or pop: the flush wins, the push is dropped and the pop returns the pre-flush head.
- Interrupt FSM:
  - IDLE → REQ when `irq_en & !empty`; drive `interrupt_vector = IRQ_ID`.
  - REQ → WAIT on `interrupt_ack==1`; vector goes to 0.
  - WAIT → IDLE when `interrupt_ack==0`. Re-request is evaluated from IDLE on the next cycle.
  - If `irq_en` is cleared in REQ, the FSM returns to IDLE and the vector goes to 0.
  - A flush does not force an exit from REQ; the CPU must ack.

## Timing

- Reset values: `bus_read_data`=0, `read_valid`=0, `interrupt_vector`=0, `overflow`=0. Internally, FIFO is empty, `irq_en`=1, FSM is IDLE and all edge flops are 0.
- Reset asserted mid-operation: all state clears asynchronously and queued events are lost.
- Push latency: count, empty and full reflect the entry 1 cycle after the edge at which `key_pressed` is first sampled high.
- Read latency: `bus_read_data` and `read_valid` update at the edge after the first cycle the read strobe is sampled high. The pop takes effect at that same edge.
- Interrupt: `interrupt_vector` asserts 2 cycles after the edge at which the FIFO becomes non-empty. It deasserts 1 cycle after `interrupt_ack` is first sampled high.
- `overflow` sets 1 cycle after the dropped push.

## Test plan

- Reset, then press 'a' (scan 0x1C, ascii 0x61) → count=1, `interrupt_vector`=1 within 3 cycles. DATA read → `bus_read_data`=0x1_1C61, `read_valid` pulses, count=0.
- Hold `bus_read_enable` on DATA for 100 cycles with 3 entries queued → exactly one pop, count=2, one `read_valid` pulse.
- Push 17 events with DEPTH=16 → full=1, `overflow`=1, STATUS[15:7]=16. Sixteen DATA reads return events 1..16 in order. A 17th read returns valid=0 (0x0).
- Hold `key_pressed` high while a DATA read edge pops from a full FIFO in the same cycle → count stays 16, `overflow` stays 0.
- Ack handshake with 2 entries: vector=1; ack high → vector=0 next cycle; ack low → vector=1 again. Write CTRL 0x1 → empty=1, and after the next ack/release the vector stays 0.
- Write CTRL 0x0 (irq_en=0), push 1 event → vector stays 0. Write CTRL 0x6 → vector=1 and `overflow` is cleared.

Source files
------------

// File: rtl/key_event_queue_if.sv
// CPU-side bus and interrupt signals of the keyboard event queue.
// The CPU side is the master; the queue is the slave.
interface key_event_queue_if;
   logic [63:0] bus_address;
   logic        bus_read_enable;
   logic        bus_write_enable;
   logic [63:0] bus_write_data;
   logic [63:0] bus_read_data;
   logic        read_valid;
   logic [3:0]  interrupt_vector;
   logic        interrupt_ack;

   modport master (
      output bus_address, bus_read_enable, bus_write_enable, bus_write_data, interrupt_ack,
      input  bus_read_data, read_valid, interrupt_vector
   );

   modport slave (
      input  bus_address, bus_read_enable, bus_write_enable, bus_write_data, interrupt_ack,
      output bus_read_data, read_valid, interrupt_vector
   );
endinterface

// File: rtl/key_event_queue.sv
// Keyboard event FIFO between the PS/2 decoder and the CPU bus.
// It provides a DATA register (a read pops), a STATUS/CTRL register and an interrupt handshake.
`ifndef Key_base
`define Key_base 64'h0000_0000_0000_1000
`endif

module key_event_queue #(
   parameter int unsigned DEPTH     = 16,
   parameter logic [63:0] BASE_ADDR = `Key_base,
   parameter logic [3:0]  IRQ_ID    = 4'd1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             key_pressed,
   input  logic [7:0]       ascii_code,
   input  logic [7:0]       scan_code,
   key_event_queue_if.slave bus,
   output logic             overflow
);
   localparam int unsigned AW         = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

   localparam logic [1:0] IRQ_IDLE = 2'd0;
   localparam logic [1:0] IRQ_REQ  = 2'd1;
   localparam logic [1:0] IRQ_WAIT = 2'd2;

   logic [15:0] mem [DEPTH];
   logic [AW:0] wr_ptr_q, rd_ptr_q, count_q;
   logic        key_q, rd_q, wr_q;
   logic        irq_en_q, overflow_q, read_valid_q;
   logic [63:0] read_data_q, read_data_d;
   logic [1:0]  irq_state_q, irq_state_d;
   logic [3:0]  vector_q;

   logic        sel_data, sel_ctrl, rd, wr, rd_edge, wr_edge, key_edge;
   logic        empty, full, flush, push_req, push, pop, drop;
   logic [8:0]  count9;
   logic [15:0] status;
   logic        unused_wdata;

   assign sel_data = (bus.bus_address == BASE_ADDR);
   assign sel_ctrl = (bus.bus_address == BASE_ADDR + 64'd8);
   assign rd       = bus.bus_read_enable & (sel_data | sel_ctrl);
   assign wr       = bus.bus_write_enable & sel_ctrl;
   assign rd_edge  = rd & ~rd_q;
   assign wr_edge  = wr & ~wr_q;
   assign key_edge = key_pressed & ~key_q;

   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_COUNT);
   assign flush    = wr_edge & bus.bus_write_data[0];
   assign push_req = key_edge & (ascii_code != 8'd0);
   assign pop      = rd_edge & sel_data & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
   assign push     = push_req & (~full | pop) & ~flush;
   assign drop     = push_req & full & ~pop & ~flush;

   assign count9 = 9'(count_q);
   assign status = {count9, 3'b000, irq_en_q, overflow_q, full, empty};

   // Only bits [2:0] of a CTRL write carry meaning.
   assign unused_wdata = ^{bus.bus_write_data[63:3], wr_ptr_q[AW], rd_ptr_q[AW]};

   always_comb begin
      read_data_d = read_data_q;
      if (rd_edge && sel_data) begin
         read_data_d = empty ? 64'd0 : {47'd0, 1'b1, mem[rd_ptr_q[AW-1:0]]};
      end else if (rd_edge && sel_ctrl) begin
         read_data_d = {48'd0, status};
      end
   end

   always_comb begin
      irq_state_d = irq_state_q;
      case (irq_state_q)
         IRQ_IDLE: if (irq_en_q && !empty) irq_state_d = IRQ_REQ;
         IRQ_REQ: begin
            if (!irq_en_q)               irq_state_d = IRQ_IDLE;
            else if (bus.interrupt_ack)  irq_state_d = IRQ_WAIT;
         end
         IRQ_WAIT: if (!bus.interrupt_ack) irq_state_d = IRQ_IDLE;
         default:  irq_state_d = IRQ_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q[AW-1:0]] <= {scan_code, ascii_code};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_q        <= 1'b0;
         rd_q         <= 1'b0;
         wr_q         <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         irq_en_q     <= 1'b1;
         overflow_q   <= 1'b0;
         read_valid_q <= 1'b0;
         read_data_q  <= 64'd0;
         irq_state_q  <= IRQ_IDLE;
         vector_q     <= 4'd0;
      end else begin
         key_q        <= key_pressed;
         rd_q         <= rd;
         wr_q         <= wr;
         read_valid_q <= rd_edge;
         read_data_q  <= read_data_d;
         irq_state_q  <= irq_state_d;
         vector_q     <= (irq_state_q == IRQ_REQ) ? IRQ_ID : 4'd0;
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
         end
         if (wr_edge) irq_en_q <= bus.bus_write_data[2];
         // A fresh drop outranks a clear in the same cycle.
         if (drop)                                overflow_q <= 1'b1;
         else if (wr_edge && bus.bus_write_data[1]) overflow_q <= 1'b0;
      end
   end

   assign bus.bus_read_data    = read_data_q;
   assign bus.read_valid       = read_valid_q;
   assign bus.interrupt_vector = vector_q;
   assign overflow             = overflow_q;
endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue: directed steps followed by a random phase,
// all checked against a queue-based model of the register behaviour.
module tb_key_event_queue;
   localparam logic [63:0] BASE = 64'h0000_0000_0000_1000;
   localparam int          DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       key_pressed;
   logic [7:0] ascii_code, scan_code;
   logic       overflow;

   key_event_queue_if kb ();

   key_event_queue #(
      .DEPTH(DEPTH), .BASE_ADDR(BASE), .IRQ_ID(4'd1)
   ) dut (
      .clk(clk), .reset_n(reset_n), .key_pressed(key_pressed), .ascii_code(ascii_code),
      .scan_code(scan_code), .bus(kb.slave), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [15:0] mq[$];
   logic        m_ovf = 1'b0;
   logic        m_irq_en = 1'b1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] exp_status();
      int n = mq.size();
      return {48'd0, 9'(n), 3'b000, m_irq_en, m_ovf, n == DEPTH, n == 0};
   endfunction

   task automatic press(input logic [7:0] sc, input logic [7:0] as, input int hold);
      key_pressed = 1'b1; scan_code = sc; ascii_code = as;
      repeat (hold) tick();
      key_pressed = 1'b0;
      tick();
      if (as != 8'd0) begin
         if (mq.size() < DEPTH) mq.push_back({sc, as});
         else m_ovf = 1'b1;
      end
   endtask

   task automatic read_data(input string tag);
      logic [63:0] exp;
      kb.bus_address = BASE; kb.bus_read_enable = 1'b1;
      tick();
      if (mq.size() > 0) exp = {47'd0, 1'b1, mq.pop_front()};
      else exp = 64'd0;
      chk({tag, "_data"}, kb.bus_read_data, exp);
      chk({tag, "_rvalid"}, {63'd0, kb.read_valid}, 64'd1);
      kb.bus_read_enable = 1'b0;
      tick();
      chk({tag, "_rvalid_low"}, {63'd0, kb.read_valid}, 64'd0);
   endtask

   task automatic read_status(input string tag);
      kb.bus_address = BASE + 64'd8; kb.bus_read_enable = 1'b1;
      tick();
      chk(tag, kb.bus_read_data, exp_status());
      kb.bus_read_enable = 1'b0;
      tick();
   endtask

   task automatic write_ctrl(input logic [63:0] val);
      kb.bus_address = BASE + 64'd8; kb.bus_write_data = val; kb.bus_write_enable = 1'b1;
      tick();
      kb.bus_write_enable = 1'b0;
      tick();
      if (val[0]) mq.delete();
      if (val[1]) m_ovf = 1'b0;
      m_irq_en = val[2];
   endtask

   task automatic ack_cycle();
      kb.interrupt_ack = 1'b1;
      repeat (3) tick();
      kb.interrupt_ack = 1'b0;
      repeat (3) tick();
   endtask

   initial begin
      int pulses;
      logic [15:0] head;
      reset_n = 1'b0; key_pressed = 1'b0; ascii_code = 8'd0; scan_code = 8'd0;
      kb.bus_address = 64'd0; kb.bus_read_enable = 1'b0; kb.bus_write_enable = 1'b0;
      kb.bus_write_data = 64'd0; kb.interrupt_ack = 1'b0;
      repeat (3) tick();
      chk("rst_rdata", kb.bus_read_data, 64'd0);
      chk("rst_rvalid", {63'd0, kb.read_valid}, 64'd0);
      chk("rst_vector", {60'd0, kb.interrupt_vector}, 64'd0);
      chk("rst_ovf", {63'd0, overflow}, 64'd0);
      reset_n = 1'b1;
      tick();
      read_status("rst_status");

      // Single press of 'a'.
      press(8'h1C, 8'h61, 1);
      read_status("a_status");
      chk("a_vector", {60'd0, kb.interrupt_vector}, 64'd1);
      chk("a_model_head", {48'd0, mq[0]}, 64'h1C61);
      read_data("a_read");
      read_status("a_status_after");
      ack_cycle();
      chk("a_vector_idle", {60'd0, kb.interrupt_vector}, 64'd0);

      // Long read strobe pops exactly once.
      press(8'h32, 8'h62, 2);
      press(8'h21, 8'h63, 3);
      press(8'h23, 8'h64, 1);
      kb.bus_address = BASE; kb.bus_read_enable = 1'b1;
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (kb.read_valid) pulses++;
      end
      kb.bus_read_enable = 1'b0;
      tick();
      head = mq.pop_front();
      chk("hold_pulses", 64'(pulses), 64'd1);
      chk("hold_data", kb.bus_read_data, {47'd0, 1'b1, head});
      read_status("hold_status");

      // Overfill, then drain in order.
      write_ctrl(64'h5);
      for (int i = 0; i < 17; i++) press(8'($urandom), 8'($urandom_range(255, 1)), 1);
      read_status("full_status");
      chk("full_ovf", {63'd0, overflow}, 64'd1);
      for (int i = 0; i < 16; i++) read_data("drain");
      read_data("drain_empty");
      read_status("drain_status");

      // Push and pop in the same cycle while full.
      write_ctrl(64'h6);
      for (int i = 0; i < 16; i++) press(8'(i + 16), 8'(i + 1), 1);
      kb.bus_address = BASE; kb.bus_read_enable = 1'b1;
      key_pressed = 1'b1; scan_code = 8'h5A; ascii_code = 8'h0D;
      tick();
      head = mq.pop_front();
      mq.push_back(16'h5A0D);
      chk("simul_data", kb.bus_read_data, {47'd0, 1'b1, head});
      kb.bus_read_enable = 1'b0; key_pressed = 1'b0;
      tick();
      read_status("simul_status");
      chk("simul_ovf", {63'd0, overflow}, 64'd0);

      // Interrupt ack handshake.
      write_ctrl(64'h5);
      ack_cycle();
      press(8'h1C, 8'h61, 1);
      press(8'h32, 8'h62, 1);
      tick();
      chk("irq_req", {60'd0, kb.interrupt_vector}, 64'd1);
      kb.interrupt_ack = 1'b1;
      tick(); tick();
      chk("irq_acked", {60'd0, kb.interrupt_vector}, 64'd0);
      kb.interrupt_ack = 1'b0;
      repeat (3) tick();
      chk("irq_rereq", {60'd0, kb.interrupt_vector}, 64'd1);
      write_ctrl(64'h1);
      read_status("irq_flush_status");
      ack_cycle();
      chk("irq_after_flush", {60'd0, kb.interrupt_vector}, 64'd0);

      // irq_en gating and overflow clear.
      write_ctrl(64'h0);
      for (int i = 0; i < 17; i++) press(8'(i), 8'(i + 65), 1);
      repeat (3) tick();
      chk("irq_disabled", {60'd0, kb.interrupt_vector}, 64'd0);
      chk("ovf_set", {63'd0, overflow}, 64'd1);
      write_ctrl(64'h6);
      chk("ovf_cleared", {63'd0, overflow}, 64'd0);
      tick();
      chk("irq_enabled", {60'd0, kb.interrupt_vector}, 64'd1);
      write_ctrl(64'h5);
      ack_cycle();

      // Random traffic against the model.
      for (int it = 0; it < 300; it++) begin
         case ($urandom_range(5, 0))
            0, 1: press(8'($urandom), ($urandom_range(7, 0) == 0) ? 8'd0 : 8'($urandom_range(255, 1)),
                        int'($urandom_range(3, 1)));
            2: read_data("rnd_read");
            3: read_status("rnd_status");
            4: write_ctrl({61'd0, 1'b1, ($urandom_range(3, 0) == 0), ($urandom_range(7, 0) == 0)});
            default: begin
               kb.bus_address = BASE + 64'd16; kb.bus_read_enable = 1'b1;
               kb.bus_write_enable = 1'b1; kb.bus_write_data = 64'h7;
               tick();
               chk("rnd_other_addr", {63'd0, kb.read_valid}, 64'd0);
               kb.bus_read_enable = 1'b0; kb.bus_write_enable = 1'b0;
               tick();
            end
         endcase
         chk("rnd_ovf", {63'd0, overflow}, {63'd0, m_ovf});
      end

      // Reset mid-operation.
      press(8'h1C, 8'h61, 1);
      press(8'h32, 8'h62, 1);
      read_status("pre_reset_status");
      reset_n = 1'b0;
      #1;
      chk("mid_rst_rdata", kb.bus_read_data, 64'd0);
      chk("mid_rst_vector", {60'd0, kb.interrupt_vector}, 64'd0);
      tick();
      reset_n = 1'b1;
      mq.delete(); m_ovf = 1'b0; m_irq_en = 1'b1;
      tick();
      read_status("post_reset_status");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
